// File: rtl/ofdmbbp_pkg.sv
// ============================================================================
// Module      : ofdmbbp_pkg
// Description : Shared state encoding and source-select codes for the DAC mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofdmbbp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] SRC_DMA  = 2'd0;
  localparam logic [1:0] SRC_BB   = 2'd1;
  localparam logic [1:0] SRC_PAT  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ofdmbbp_sfifo.sv
// ============================================================================
// Module      : ofdmbbp_sfifo
// Description : Show-ahead synchronous FIFO with level output and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofdmbbp_sfifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_r == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level_r != '0);
  assign rdata   = mem[rd_ptr];
  assign level   = level_r;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/ofdmbbp_dac_mux.sv
// ============================================================================
// Module      : ofdmbbp_dac_mux
// Description : DAC source mux with prefilled baseband sample FIFO and FSM.
//               Define OFDMBBP_DAC_MUX_PATTERN_EN to include the ramp pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofdmbbp_dac_mux
  import ofdmbbp_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int BB_WIDTH = 12,
  parameter int DEPTH    = 16,
  parameter int PREFILL  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctl_enable,
  input  logic [1:0]                   ctl_src,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_CH*BB_WIDTH-1:0]   s_data_i,
  input  logic [NUM_CH*BB_WIDTH-1:0]   s_data_q,
  input  logic                         dac_valid,
  input  logic [NUM_CH*16-1:0]         dma_data_i,
  input  logic [NUM_CH*16-1:0]         dma_data_q,
  input  logic                         dma_dunf,
  output logic [NUM_CH*16-1:0]         dac_data_i,
  output logic [NUM_CH*16-1:0]         dac_data_q,
  output logic                         dac_dunf,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic [15:0]                  unf_count,
  output logic [1:0]                   state
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int BBW = NUM_CH * BB_WIDTH;
  localparam int DW  = NUM_CH * 16;

  logic           en_meta;
  logic           en_s;
  state_t         state_r;
  state_t         state_nx;
  logic           flush;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           run_strobe;
  logic           underflow;
  logic [2*BBW-1:0] fifo_rdata;
  logic [DW-1:0]  bb_i16;
  logic [DW-1:0]  bb_q16;
  logic [DW-1:0]  nxt_i;
  logic [DW-1:0]  nxt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      en_meta <= ctl_enable;
      en_s    <= en_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:    if (en_s) state_nx = ST_PREFILL;
      ST_PREFILL: if (fifo_level >= LW'(PREFILL)) state_nx = ST_RUN;
      ST_RUN:     state_nx = ST_RUN;
      default:    state_nx = ST_IDLE;
    endcase
    if (!en_s) state_nx = ST_IDLE;
  end

  // Flushing on the transition edge leaves the FIFO empty as IDLE is entered.
  assign flush      = (state_nx == ST_IDLE);
  assign s_ready    = (state_r != ST_IDLE) && en_s && !fifo_full;
  assign push       = s_valid && s_ready;
  assign run_strobe = (state_r == ST_RUN) && dac_valid;
  assign pop        = run_strobe && (fifo_level != '0);
  assign underflow  = run_strobe && (fifo_level == '0);
  assign state      = state_r;

  ofdmbbp_sfifo #(
    .WIDTH (2*BBW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({s_data_q, s_data_i}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .level (fifo_level)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign bb_i16[c*16 +: 16] = 16'(fifo_rdata[c*BB_WIDTH +: BB_WIDTH]) << (16 - BB_WIDTH);
    assign bb_q16[c*16 +: 16] = 16'(fifo_rdata[BBW + c*BB_WIDTH +: BB_WIDTH]) << (16 - BB_WIDTH);
  end

`ifdef OFDMBBP_DAC_MUX_PATTERN_EN
  logic [15:0] pat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 pat_r <= '0;
    else if (dac_valid && ctl_src == SRC_PAT) pat_r <= pat_r + 16'd1;
  end
`endif

  always_comb begin
    nxt_i = '0;
    nxt_q = '0;
    case (ctl_src)
      SRC_DMA: begin
        nxt_i = dma_data_i;
        nxt_q = dma_data_q;
      end
      SRC_BB: begin
        if (pop) begin
          nxt_i = bb_i16;
          nxt_q = bb_q16;
        end
      end
`ifdef OFDMBBP_DAC_MUX_PATTERN_EN
      SRC_PAT: begin
        nxt_i = {NUM_CH{pat_r}};
        nxt_q = {NUM_CH{~pat_r}};
      end
`endif
      default: begin
        nxt_i = '0;
        nxt_q = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data_i <= '0;
      dac_data_q <= '0;
      dac_dunf   <= 1'b0;
    end else begin
      dac_dunf <= (ctl_src == SRC_DMA) ? dma_dunf : underflow;
      if (dac_valid) begin
        dac_data_i <= nxt_i;
        dac_data_q <= nxt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      unf_count <= '0;
    else if (state_r == ST_IDLE && state_nx == ST_PREFILL)
      unf_count <= '0;
    else if (underflow && unf_count != 16'hFFFF)
      unf_count <= unf_count + 16'd1;
  end

endmodule

`default_nettype wire

// File: tb/tb_ofdmbbp_dac_mux.sv
// Directed bench for ofdmbbp_dac_mux at default parameters.
`default_nettype none

module tb_ofdmbbp_dac_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctl_enable = 1'b0;
  logic [1:0]  ctl_src = 2'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data_i = '0;
  logic [11:0] s_data_q = '0;
  logic        dac_valid = 1'b0;
  logic [15:0] dma_data_i = '0;
  logic [15:0] dma_data_q = '0;
  logic        dma_dunf = 1'b0;
  logic [15:0] dac_data_i;
  logic [15:0] dac_data_q;
  logic        dac_dunf;
  logic [4:0]  fifo_level;
  logic [15:0] unf_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofdmbbp_dac_mux dut (
    .clk        (clk),
    .rst        (rst),
    .ctl_enable (ctl_enable),
    .ctl_src    (ctl_src),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data_i   (s_data_i),
    .s_data_q   (s_data_q),
    .dac_valid  (dac_valid),
    .dma_data_i (dma_data_i),
    .dma_data_q (dma_data_q),
    .dma_dunf   (dma_dunf),
    .dac_data_i (dac_data_i),
    .dac_data_q (dac_data_q),
    .dac_dunf   (dac_dunf),
    .fifo_level (fifo_level),
    .unf_count  (unf_count),
    .state      (state)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
    int n = 0;
    while (state !== exp && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e16;

    // Reset state
    step();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_data_i", 32'(dac_data_i), 32'd0);
    check("rst_dunf", 32'(dac_dunf), 32'd0);
    check("rst_unf", 32'(unf_count), 32'd0);
    rst = 1'b0;
    step();

    // DMA pass-through in IDLE
    ctl_src = 2'd0; dma_data_i = 16'h1234; dma_data_q = 16'hABCD; dma_dunf = 1'b1; dac_valid = 1'b1;
    step();
    check("dma_i", 32'(dac_data_i), 32'h1234);
    check("dma_q", 32'(dac_data_q), 32'hABCD);
    check("dma_dunf", 32'(dac_dunf), 32'd1);
    dac_valid = 1'b0; dma_dunf = 1'b0; dma_data_i = 16'h5555;
    step();
    check("dma_dunf_low", 32'(dac_dunf), 32'd0);
    check("dma_hold", 32'(dac_data_i), 32'h1234);

    // Pattern source
    ctl_src = 2'd2; dac_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef OFDMBBP_DAC_MUX_PATTERN_EN
      check("pat_i", 32'(dac_data_i), 32'(k));
      check("pat_q", 32'(dac_data_q), 32'(16'hFFFF - 16'(k)));
`else
      check("pat_i", 32'(dac_data_i), 32'd0);
      check("pat_q", 32'(dac_data_q), 32'd0);
`endif
    end
    dac_valid = 1'b0;

    // Enable baseband path
    ctl_src = 2'd1; ctl_enable = 1'b1;
    wait_state(2'd1, 10, "to_prefill");
    check("prefill_ready", 32'(s_ready), 32'd1);
    dac_valid = 1'b1;
    step();
    check("prefill_zero", 32'(dac_data_i), 32'd0);
    check("prefill_dunf", 32'(dac_dunf), 32'd0);
    check("prefill_unf", 32'(unf_count), 32'd0);
    dac_valid = 1'b0;

    s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data_i = 12'h7FF - 12'(k);
      s_data_q = 12'(k);
      step();
    end
    s_valid = 1'b0;
    check("prefill_level", 32'(fifo_level), 32'd8);
    step();
    check("to_run", 32'(state), 32'd2);

    // Drain
    dac_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      e16 = {12'h7FF - 12'(k), 4'h0};
      check("drain_i", 32'(dac_data_i), 32'(e16));
      e16 = {12'(k), 4'h0};
      check("drain_q", 32'(dac_data_q), 32'(e16));
    end
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_dunf", 32'(dac_dunf), 32'd0);
    dac_valid = 1'b0;
    step();

    // Underflow pulses
    for (int k = 0; k < 3; k++) begin
      dac_valid = 1'b1;
      step();
      check("unf_pulse", 32'(dac_dunf), 32'd1);
      check("unf_zero", 32'(dac_data_i), 32'd0);
      dac_valid = 1'b0;
      step();
      check("unf_single", 32'(dac_dunf), 32'd0);
    end
    check("unf_count3", 32'(unf_count), 32'd3);

    // Fill to full
    s_valid = 1'b1; s_data_q = '0;
    for (int k = 0; k < 16; k++) begin
      s_data_i = 12'(k + 1);
      step();
    end
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ready", 32'(s_ready), 32'd0);
    s_data_i = 12'h123;
    step();
    check("full_hold", 32'(fifo_level), 32'd16);
    dac_valid = 1'b1;
    step();
    check("full_pop_i", 32'(dac_data_i), 32'h0010);
    check("full_pop_level", 32'(fifo_level), 32'd15);
    dac_valid = 1'b0;
    step();
    check("late_push", 32'(fifo_level), 32'd16);
    s_valid = 1'b0;

    // Disable mid-RUN
    ctl_enable = 1'b0;
    wait_state(2'd0, 4, "to_idle");
    check("idle_level", 32'(fifo_level), 32'd0);
    check("idle_ready", 32'(s_ready), 32'd0);
    dac_valid = 1'b1;
    step();
    check("idle_zero", 32'(dac_data_i), 32'd0);
    dac_valid = 1'b0;
    check("idle_unf_kept", 32'(unf_count), 32'd3);

    // Re-enable clears counter, then reset mid-operation
    ctl_enable = 1'b1;
    wait_state(2'd1, 10, "reprefill");
    check("unf_cleared", 32'(unf_count), 32'd0);
    s_valid = 1'b1; s_data_i = 12'h555;
    step(); step(); step();
    s_valid = 1'b0;
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    #1;
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_ready", 32'(s_ready), 32'd0);
    step();
    rst = 1'b0;
    dac_valid = 1'b1;
    step();
    check("post_rst_zero", 32'(dac_data_i), 32'd0);
    check("post_rst_dunf", 32'(dac_dunf), 32'd0);
    dac_valid = 1'b0;

    // DMA pass-through while not IDLE
    wait_state(2'd1, 10, "dma_prefill");
    ctl_src = 2'd0; dma_data_i = 16'h1234; dma_dunf = 1'b1; dac_valid = 1'b1;
    step();
    check("dma_prefill_i", 32'(dac_data_i), 32'h1234);
    check("dma_prefill_dunf", 32'(dac_dunf), 32'd1);
    dac_valid = 1'b0; dma_dunf = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofdmbbp_dac_mux.md
OFDMBBP_DAC_MUX -- requirements
Module: ofdmbbp_dac_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of I/Q channel pairs (1 or 2).
REQ-002 SHALL have parameter BB_WIDTH, default 12, baseband sample width per component (1..16).
REQ-003 SHALL have parameter DEPTH, default 16, sample FIFO depth in entries (power of 2, >=4).
REQ-004 SHALL have parameter PREFILL, default 8, FIFO level required before draining starts (1..DEPTH).
REQ-005 SHALL have ports: clk  in  1  DAC interface clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: ctl_enable  in  1  baseband path enable, asynchronous to clk; ctl_src  in  2  source select, quasi-static.
REQ-007 SHALL have ports: s_valid  in  1; s_ready  out  1; s_data_i, s_data_q  in  NUM_CH*BB_WIDTH  baseband sample input (channel n at bits [n*BB_WIDTH +: BB_WIDTH]).
REQ-008 SHALL have ports: dac_valid  in  1  sample strobe; dma_data_i, dma_data_q  in  NUM_CH*16; dma_dunf  in  1.
REQ-009 SHALL have ports: dac_data_i, dac_data_q  out  NUM_CH*16; dac_dunf  out  1.
REQ-010 SHALL have ports: fifo_level  out  clog2(DEPTH)+1; unf_count  out  16; state  out  2.

Function
REQ-011 ctl_enable SHALL pass through a 2-flop synchroniser; only the synchronised copy (en_s) is used.
REQ-012 FIFO SHALL accept a sample when s_valid && s_ready; s_ready SHALL be 0 when fifo_level == DEPTH, or when state is IDLE.
REQ-013 State machine SHALL have states IDLE(0), PREFILL(1), RUN(2); IDLE->PREFILL when en_s==1; PREFILL->RUN when fifo_level >= PREFILL; any state->IDLE when en_s==0.
REQ-014 Entering IDLE SHALL flush the FIFO (level 0) in the same cycle; unf_count SHALL be cleared on IDLE->PREFILL.
REQ-015 FIFO SHALL be popped only in RUN on a cycle with dac_valid==1 and fifo_level!=0.
REQ-016 In RUN, dac_valid==1 with fifo_level==0 SHALL be an underflow: output zero sample, assert dac_dunf for exactly 1 cycle, increment unf_count saturating at 16'hFFFF.
REQ-017 Push and pop in the same cycle SHALL leave fifo_level unchanged; push into an empty FIFO SHALL NOT bypass to the output (still underflow that cycle).
REQ-018 Baseband samples SHALL be left-justified into 16 bits, low (16-BB_WIDTH) bits zero.
REQ-019 ctl_src: 0 = DMA pass-through, 1 = baseband FIFO, 2 = pattern (REQ-027), 3 = all zeros.
REQ-020 Outputs SHALL be registered; dac_data SHALL update only on cycles with dac_valid==1, one cycle after the strobe (latency 1).
REQ-021 With ctl_src==1 in IDLE or PREFILL, dac_data SHALL be zero and no underflow SHALL be counted.
REQ-022 With ctl_src==0, dac_data SHALL be dma_data and dac_dunf SHALL equal dma_dunf registered; otherwise dac_dunf SHALL follow REQ-016 only.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or go below 0.

Reset
REQ-024 On rst: state=IDLE, FIFO empty, sync flops 0, dac_data_i/q=0, dac_dunf=0, unf_count=0, s_ready=0.
REQ-025 rst asserted mid-operation SHALL discard FIFO contents immediately; the first output after release SHALL be zero.

Configuration
REQ-026 Macro OFDMBBP_DAC_MUX_PATTERN_EN SHALL select pattern generator inclusion.
REQ-027 With macro defined: ctl_src==2 outputs a 16-bit ramp, incremented by 1 per dac_valid, same value on all I, Q bitwise-inverted, reset to 0 on rst. Without it: ctl_src==2 behaves as 3 (zeros), no ramp logic present.

Structure
REQ-028 Package ofdmbbp_pkg SHALL hold state encoding (IDLE/PREFILL/RUN) and ctl_src codes (SRC_DMA, SRC_BB, SRC_PAT, SRC_ZERO).
REQ-029 FIFO SHALL be sub-module ofdmbbp_sfifo (parametrised width, depth, level output, flush input); the mux/FSM stays in the top.

Verification
REQ-030 Enable with ctl_src=1, push 8 samples 12'h7FF.. -> PREFILL->RUN after 8th push; next dac_valid yields dac_data_i=16'h7FF0 one cycle later.
REQ-031 RUN with FIFO drained, 3 dac_valid strobes -> 3 zero samples, 3 single-cycle dac_dunf pulses, unf_count=3.
REQ-032 Push 16 samples with no dac_valid (DEPTH=16) -> s_ready=0, fifo_level=16, 17th sample held until a pop.
REQ-033 Deassert ctl_enable mid-RUN -> IDLE 3 cycles later at most, fifo_level=0, s_ready=0, outputs zero.
REQ-034 ctl_src=0, dma_data_i=16'h1234, dma_dunf=1 -> dac_data_i=16'h1234, dac_dunf=1 regardless of state.
REQ-035 With PATTERN_EN, ctl_src=2, 4 dac_valid -> I=0,1,2,3 and Q=FFFF,FFFE,FFFD,FFFC; without macro -> zeros.
